// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX forwarding, load-use bubbles, branch flush and M-extension stall sequencing; define HAZARD_PERF_EN for perf counters
module hazard_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_IFID,
  input  logic [4:0] rs2_IFID,
  input  logic [4:0] rs1_IDEX,
  input  logic [4:0] rs2_IDEX,
  input  logic [4:0] rd_IDEX,
  input  logic       memRead_IDEX,
  input  logic [4:0] rd_EXMEM,
  input  logic       RegWrite_EXMEM,
  input  logic [4:0] rd_MEMWB,
  input  logic       RegWrite_MEMWB,
  input  logic       PCSrc,
  input  logic       mdu_valid_IDEX,
  input  logic       mdu_div_IDEX,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       PCWrite,
  output logic       IFID_write,
  output logic       IDEX_write,
  output logic       IDEX_bubble,
  output logic       EXMEM_bubble,
  output logic       IFID_flush,
  output logic       mdu_start,
  output logic       mdu_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic lat_gt1, idle_op, mdu_stall, lu, lu_stall;
  logic [CNT_W-1:0] lat_m2;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (RegWrite_EXMEM && rd_EXMEM != 5'd0 && rd_EXMEM == rs) ? 2'b10 :
           (RegWrite_MEMWB && rd_MEMWB != 5'd0 && rd_MEMWB == rs) ? 2'b01 : 2'b00;
  endfunction

  always_comb begin
    lat_gt1   = mdu_div_IDEX ? (DIV_LAT > 1) : (MUL_LAT > 1);
    lat_m2    = mdu_div_IDEX ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
    idle_op   = state == IDLE && mdu_valid_IDEX;
    mdu_stall = (idle_op && lat_gt1) || (state == BUSY && cnt != '0);
    lu        = memRead_IDEX && rd_IDEX != 5'd0 && (rd_IDEX == rs1_IFID || rd_IDEX == rs2_IFID);
    lu_stall  = lu && !PCSrc && !mdu_stall;
    ForwardA     = rst ? 2'b00 : fwd(rs1_IDEX);
    ForwardB     = rst ? 2'b00 : fwd(rs2_IDEX);
    PCWrite      = rst || !(mdu_stall || lu_stall);
    IFID_write   = PCWrite;
    IDEX_write   = rst || !mdu_stall;
    IDEX_bubble  = !rst && (PCSrc || lu_stall);
    EXMEM_bubble = !rst && mdu_stall;
    IFID_flush   = !rst && PCSrc;
    mdu_start    = !rst && idle_op && lat_gt1;
    mdu_done     = !rst && ((idle_op && !lat_gt1) || (state == BUSY && cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (idle_op && lat_gt1) begin
        state <= BUSY;
        cnt   <= lat_m2;
      end
    end else if (cnt == '0) begin
      state <= IDLE;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(!PCWrite);
      perf_flush_cnt <= perf_flush_cnt + 32'(IFID_flush);
      perf_lu_cnt    <= perf_lu_cnt + 32'(lu_stall);
    end
  end
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It generates the ForwardA/ForwardB selects consumed by the EX stage operand muxes, detects load-use hazards and inserts bubbles, and flushes IF/ID and ID/EX on a taken branch or jump (PCSrc). A small FSM sequences multi-cycle M-extension ops occupying EX, freezing the front of the pipeline until the op completes.

Parameters:
MUL_LAT, 1, EX occupancy in cycles for MUL/MULH* (>=1)
DIV_LAT, 32, EX occupancy in cycles for DIV/DIVU/REM/REMU (>=1)
CNT_W, 6, width of latency down-counter; must hold max(MUL_LAT,DIV_LAT)-2

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
rs1_IFID  in  5  rs1 of instruction in ID
rs2_IFID  in  5  rs2 of instruction in ID
rs1_IDEX  in  5  rs1 of instruction in EX
rs2_IDEX  in  5  rs2 of instruction in EX
rd_IDEX  in  5  rd of instruction in EX
memRead_IDEX  in  1  EX instruction is a load
rd_EXMEM  in  5  rd in MEM
RegWrite_EXMEM  in  1  MEM instruction writes rd
rd_MEMWB  in  5  rd in WB
RegWrite_MEMWB  in  1  WB instruction writes rd
PCSrc  in  1  branch taken / jump resolved in EX
mdu_valid_IDEX  in  1  EX holds an M-extension op
mdu_div_IDEX  in  1  that op is div/rem (else mul)
ForwardA  out  2  EX operand-A select
ForwardB  out  2  EX operand-B select
PCWrite  out  1  PC update enable
IFID_write  out  1  IF/ID register enable
IDEX_write  out  1  ID/EX register enable
IDEX_bubble  out  1  load NOPs (zero controls) into ID/EX
EXMEM_bubble  out  1  load NOPs into EX/MEM
IFID_flush  out  1  clear IF/ID
mdu_start  out  1  one-cycle start pulse to MDU
mdu_done  out  1  final EX cycle of multi-cycle op

Behaviour:
- Clock clk, reset rst: synchronous, active-high.
- Forwarding (combinational): ForwardA=2'b10 if RegWrite_EXMEM && rd_EXMEM!=0 && rd_EXMEM==rs1_IDEX; else 2'b01 if RegWrite_MEMWB && rd_MEMWB!=0 && rd_MEMWB==rs1_IDEX; else 2'b00. ForwardB identical on rs2_IDEX. EX/MEM wins over MEM/WB. Encoding: 00 regfile, 01 WB data, 10 EX/MEM ALU result.
- Load-use: lu = memRead_IDEX && rd_IDEX!=0 && (rd_IDEX==rs1_IFID || rd_IDEX==rs2_IFID). When lu and no flush/MDU stall: PCWrite=0, IFID_write=0, IDEX_bubble=1, exactly one cycle per occurrence.
- Flush: PCSrc=1 -> IFID_flush=1, IDEX_bubble=1 same cycle; PCWrite=1. Flush overrides load-use.
- MDU FSM, states IDLE, BUSY; cnt is CNT_W bits. LAT = DIV_LAT if mdu_div_IDEX else MUL_LAT.
  - IDLE, mdu_valid_IDEX, LAT==1: no stall, mdu_done=1, stay IDLE.
  - IDLE, mdu_valid_IDEX, LAT>1: mdu_start=1, stall, cnt<=LAT-2, ->BUSY.
  - BUSY, cnt!=0: stall, cnt<=cnt-1.
  - BUSY, cnt==0: no stall, mdu_done=1, ->IDLE (op leaves EX at this edge).
  - Stall = PCWrite=0, IFID_write=0, IDEX_write=0, EXMEM_bubble=1. Total stall cycles = LAT-1; EX occupancy = LAT.
  - MDU stall overrides load-use; PCSrc cannot coincide (EX holds one instruction).
- Reset values: state IDLE, cnt 0; while rst=1 all outputs forced inactive: ForwardA/B=00, PCWrite=1, IFID_write=1, IDEX_write=1, all bubble/flush/mdu_* = 0. Reset mid-BUSY aborts op; next cycle IDLE.

Optional Feature:
HAZARD_PERF_EN: when defined, adds outputs perf_stall_cnt[31:0] (increments each cycle PCWrite=0), perf_flush_cnt[31:0] (increments each cycle IFID_flush=1), perf_lu_cnt[31:0] (load-use bubbles); zero on rst, wrap at 2^32. When undefined, ports and counters absent; core behaviour identical.

Test Plan:
RegWrite_EXMEM=1, rd_EXMEM=5, RegWrite_MEMWB=1, rd_MEMWB=5, rs1_IDEX=5 -> ForwardA=10; set rd_EXMEM=0 -> ForwardA=01; rs1_IDEX=0 -> 00.
memRead_IDEX=1, rd_IDEX=7, rs2_IFID=7 for one cycle -> PCWrite=0, IFID_write=0, IDEX_bubble=1 that cycle only; rd_IDEX=0 -> no stall.
PCSrc=1 together with load-use condition -> IFID_flush=1, IDEX_bubble=1, PCWrite=1.
mdu_valid_IDEX=1, mdu_div_IDEX=1, DIV_LAT=32 -> mdu_start one cycle, PCWrite=0 for exactly 31 cycles, mdu_done on cycle 32, then IDLE; back-to-back div restarts with new mdu_start.
MUL_LAT=1 mul -> no stall, mdu_done=1, mdu_start=0; MUL_LAT=2 -> exactly one stall cycle.
rst=1 on 10th BUSY cycle of a div -> next cycle state IDLE, PCWrite=1, mdu_done=0; perf counters (HAZARD_PERF_EN) read 0.
